// File: rtl/mysystem_pio_pkg.sv
// Shared register map and edge-select encodings for the PIO capture block.
package mysystem_pio_pkg;

   localparam logic [1:0] ADDR_DATA     = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK  = 2'd1;
   localparam logic [1:0] ADDR_RESERVED = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

   localparam int unsigned EDGE_RISING  = 0;
   localparam int unsigned EDGE_FALLING = 1;
   localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/mysystem_pio_sync.sv
// WIDTH-wide two-stage synchronizer, cleared to 0 on reset.
module mysystem_pio_sync #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= i_async;
         r_s2 <= r_s1;
      end
   end

   assign o_sync = r_s2;

endmodule

// File: rtl/mysystem_pio_capture.sv
// Avalon-MM PIO input port with synchronizer, per-bit edge capture and masked level irq.
module mysystem_pio_capture
   import mysystem_pio_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned EDGE_TYPE  = EDGE_RISING,
   parameter logic [31:0] RESET_MASK = 32'h0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] w_s2;
   logic [WIDTH-1:0] r_s3;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] r_edgecap;
   logic [WIDTH-1:0] r_irqmask;
   logic [WIDTH-1:0] w_clr;
   logic             w_wr;
   logic [31:0]      w_rdata;
   logic             w_unused_wdata;

   mysystem_pio_sync #(
      .WIDTH (WIDTH)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_async (in_port),
      .o_sync  (w_s2)
   );

   generate
      if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
         assign w_edge = ~w_s2 & r_s3;
      end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
         assign w_edge = w_s2 ^ r_s3;
      end else begin : g_rise
         assign w_edge = w_s2 & ~r_s3;
      end
   endgenerate

   assign w_wr  = chipselect & ~write_n;
   assign w_clr = (w_wr && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

   // Bits above WIDTH are intentionally ignored.
   assign w_unused_wdata = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s3      <= '0;
         r_edgecap <= '0;
         r_irqmask <= RESET_MASK[WIDTH-1:0];
      end else begin
         r_s3      <= w_s2;
         // A new edge beats a simultaneous write-1-to-clear.
         r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
         if (w_wr && (address == ADDR_IRQMASK)) begin
            r_irqmask <= writedata[WIDTH-1:0];
         end
      end
   end

   assign irq = |(r_edgecap & r_irqmask);

   always_comb begin
      w_rdata = '0;
      case (address)
         ADDR_DATA:     w_rdata[WIDTH-1:0] = w_s2;
         ADDR_IRQMASK:  w_rdata[WIDTH-1:0] = r_irqmask;
         ADDR_EDGECAP:  w_rdata[WIDTH-1:0] = r_edgecap;
         ADDR_RESERVED: w_rdata = '0;
         default:       w_rdata = '0;
      endcase
   end

   assign readdata = w_rdata;

endmodule
